// File: rtl/secded_mem_ctrl.sv
// SECDED-protected word memory: Hamming encode on write, decode/correct on read with
// write-back of corrected words, plus a periodic background scrubber and error CSRs.
module secded_mem_ctrl #(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 64,
  parameter int SCRUB_INTERVAL = 1024,
  parameter int CNT_W          = 16,
  localparam int P_W = (DATA_W + 4 <= 8)   ? 3 :
                       (DATA_W + 5 <= 16)  ? 4 :
                       (DATA_W + 6 <= 32)  ? 5 :
                       (DATA_W + 7 <= 64)  ? 6 :
                       (DATA_W + 8 <= 128) ? 7 :
                       (DATA_W + 9 <= 256) ? 8 :
                       (DATA_W + 10 <= 512) ? 9 : 10,
  localparam int CODE_W = DATA_W + P_W + 1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [AW-1:0]     req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [CODE_W-1:0] inj_mask,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_serr,
  output logic              rsp_derr,
  input  logic              scrub_en,
  output logic [CNT_W-1:0]  serr_cnt,
  output logic [CNT_W-1:0]  derr_cnt,
  output logic [AW-1:0]     last_err_addr
);

  localparam int TW = $clog2(SCRUB_INTERVAL);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_CHK, S_WB} state_t;

  state_t             state, state_nxt;
  logic [CODE_W-1:0]  mem [DEPTH];
  logic [CODE_W-1:0]  rd_cw;
  logic [AW-1:0]      op_addr;
  logic               op_scrub;
  logic [AW-1:0]      scrub_ptr;
  logic [TW-1:0]      scrub_timer;
  logic               scrub_pending;

  logic               host_wr, launch_rd, launch_scrub, chk, wb_wr;
  logic [P_W-1:0]     syn;
  logic               ov, dec_serr, dec_derr;
  logic [CODE_W-1:0]  fixed_cw;
  logic [DATA_W-1:0]  dec_data;

  // Data bits fill non-power-of-two positions; check bit i covers positions with bit i set.
  function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] cw;
    logic              b;
    int                k;
    cw = '0;
    k  = 0;
    for (int pos = 1; pos < CODE_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = d[k];
        k++;
      end
    end
    for (int i = 0; i < P_W; i++) begin
      b = 1'b0;
      for (int pos = 1; pos < CODE_W; pos++) begin
        if (((pos >> i) & 1) == 1) b = b ^ cw[pos];
      end
      cw[1 << i] = b;
    end
    cw[0] = ^cw;
    return cw;
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] cw);
    logic [DATA_W-1:0] d;
    int                k;
    d = '0;
    k = 0;
    for (int pos = 1; pos < CODE_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[k] = cw[pos];
        k++;
      end
    end
    return d;
  endfunction

  always_comb begin
    syn = '0;
    for (int pos = 1; pos < CODE_W; pos++) begin
      if (rd_cw[pos]) syn = syn ^ P_W'(pos);
    end
    ov       = ^rd_cw;
    dec_serr = ov && (int'(syn) < CODE_W);
    dec_derr = (ov && (int'(syn) >= CODE_W)) || (!ov && (syn != '0));
    fixed_cw = rd_cw;
    // A syndrome of zero with odd parity means only the overall parity bit flipped.
    if (dec_serr && (syn != '0)) fixed_cw[syn] = ~rd_cw[syn];
    dec_data = extract(fixed_cw);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (launch_scrub || launch_rd) state_nxt = S_RD;
      S_RD:    state_nxt = S_CHK;
      S_CHK:   state_nxt = dec_serr ? S_WB : S_IDLE;
      S_WB:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready only depends on controller state, never on req_valid.
  always_comb begin
    req_ready    = 1'b0;
    host_wr      = 1'b0;
    launch_rd    = 1'b0;
    launch_scrub = 1'b0;
    chk          = 1'b0;
    wb_wr        = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready    = !scrub_pending && !rst;
        launch_scrub = scrub_pending;
        host_wr      = req_valid && req_ready && req_we;
        launch_rd    = req_valid && req_ready && !req_we;
      end
      S_CHK:   chk   = 1'b1;
      S_WB:    wb_wr = 1'b1;
      default: ;
    endcase
  end

  assign rsp_valid = chk && !op_scrub;
  assign rsp_rdata = rsp_valid ? dec_data : '0;
  assign rsp_serr  = rsp_valid && dec_serr;
  assign rsp_derr  = rsp_valid && dec_derr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_addr       <= '0;
      op_scrub      <= 1'b0;
      rd_cw         <= '0;
      scrub_ptr     <= '0;
      scrub_timer   <= '0;
      scrub_pending <= 1'b0;
      serr_cnt      <= '0;
      derr_cnt      <= '0;
      last_err_addr <= '0;
    end else begin
      if (launch_scrub) begin
        op_addr  <= scrub_ptr;
        op_scrub <= 1'b1;
      end else if (launch_rd) begin
        op_addr  <= req_addr;
        op_scrub <= 1'b0;
      end
      if (state == S_RD) rd_cw <= mem[op_addr];
      if (chk) begin
        if (dec_serr || dec_derr) last_err_addr <= op_addr;
        if (dec_serr && (serr_cnt != '1)) serr_cnt <= serr_cnt + 1'b1;
        if (dec_derr && (derr_cnt != '1)) derr_cnt <= derr_cnt + 1'b1;
        if (op_scrub) scrub_ptr <= scrub_ptr + 1'b1;
      end
      // The timer is frozen while a scrub waits for the controller to go idle.
      if (!scrub_en) begin
        scrub_timer   <= '0;
        scrub_pending <= 1'b0;
      end else if (scrub_pending) begin
        if (launch_scrub) scrub_pending <= 1'b0;
      end else if (scrub_timer == TW'(SCRUB_INTERVAL - 1)) begin
        scrub_pending <= 1'b1;
        scrub_timer   <= '0;
      end else begin
        scrub_timer <= scrub_timer + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (host_wr)    mem[req_addr] <= encode(req_wdata) ^ inj_mask;
    else if (wb_wr) mem[op_addr]  <= encode(dec_data);
  end

endmodule

// File: tb/tb_secded_mem_ctrl.sv
// Bench for secded_mem_ctrl: directed scenarios plus random traffic checked against a
// codeword-level reference model with an expected-response queue.
module tb_secded_mem_ctrl;
  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int CW    = 39;
  localparam int CNT_W = 2;
  localparam int SI    = 8;
  localparam int CMAX  = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [AW-1:0]     req_addr = '0;
  logic [DW-1:0]     req_wdata = '0;
  logic [CW-1:0]     inj_mask = '0;
  logic              rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_serr, rsp_derr;
  logic              scrub_en = 1'b0;
  logic [CNT_W-1:0]  serr_cnt, derr_cnt;
  logic [AW-1:0]     last_err_addr;

  secded_mem_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .SCRUB_INTERVAL(SI), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .inj_mask(inj_mask),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_serr(rsp_serr), .rsp_derr(rsp_derr),
    .scrub_en(scrub_en), .serr_cnt(serr_cnt), .derr_cnt(derr_cnt), .last_err_addr(last_err_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [CW-1:0]   mdl_mem [DEPTH];
  int              m_serr = 0, m_derr = 0;
  logic [AW-1:0]   m_last = '0;
  logic [DW+1:0]   exp_q[$];
  int              due_q[$];
  logic            undo_valid = 1'b0;
  logic [AW-1:0]   undo_addr = '0;
  logic [CW-1:0]   undo_cw = '0;
  int              undo_at = 0;
  int              vectors = 0, fails = 0;
  logic [DW-1:0]   got_data = '0;
  logic            got_serr = 1'b0, got_derr = 1'b0;
  logic [DW-1:0]   mon_d;
  logic            mon_s, mon_e;
  logic [DW+1:0]   cmp_e;

  // Check bits are the binary digits of the XOR of the positions holding a 1 data bit.
  function automatic logic [CW-1:0] m_encode(input logic [DW-1:0] d);
    logic [CW-1:0] cw;
    int            s, k;
    cw = '0; s = 0; k = 0;
    for (int pos = 1; pos < CW; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = d[k];
        if (d[k]) s = s ^ pos;
        k++;
      end
    end
    for (int i = 0; i < 6; i++) cw[1 << i] = s[i];
    cw[0] = ^cw;
    return cw;
  endfunction

  task automatic m_decode(input logic [CW-1:0] cw_in, output logic [DW-1:0] d,
                          output logic se, output logic de);
    logic [CW-1:0] cw;
    int            syn, k;
    logic          ov;
    cw = cw_in; syn = 0;
    for (int pos = 1; pos < CW; pos++) if (cw[pos]) syn = syn ^ pos;
    ov = ^cw;
    se = ov && (syn < CW);
    de = !se && (ov || syn != 0);
    if (se && syn != 0) cw[syn] = ~cw[syn];
    d = '0; k = 0;
    for (int pos = 1; pos < CW; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[k] = cw[pos];
        k++;
      end
    end
  endtask

  function automatic logic [CW-1:0] rand_mask(input int nbits);
    logic [CW-1:0] m;
    m = '0;
    for (int i = 0; i < nbits; i++) m[$urandom_range(0, CW - 1)] ^= 1'b1;
    return m;
  endfunction

  // Monitor: observes accepted requests and advances the model.
  always @(negedge clk) begin
    if (rst) begin
      if (undo_valid) mdl_mem[undo_addr] = undo_cw;
      undo_valid = 1'b0;
      exp_q.delete();
      due_q.delete();
      m_serr = 0; m_derr = 0; m_last = '0;
    end else begin
      if (undo_valid && cyc >= undo_at) undo_valid = 1'b0;
      if (req_valid && req_ready) begin
        if (req_we) begin
          mdl_mem[req_addr] = m_encode(req_wdata) ^ inj_mask;
        end else begin
          m_decode(mdl_mem[req_addr], mon_d, mon_s, mon_e);
          exp_q.push_back({mon_d, mon_s, mon_e});
          due_q.push_back(cyc + 2);
          if (mon_s || mon_e) m_last = req_addr;
          if (mon_s && m_serr < CMAX) m_serr++;
          if (mon_e && m_derr < CMAX) m_derr++;
          if (mon_s) begin
            undo_valid = 1'b1;
            undo_addr  = req_addr;
            undo_cw    = mdl_mem[req_addr];
            undo_at    = cyc + 4;
            mdl_mem[req_addr] = m_encode(mon_d);
          end
        end
      end
    end
  end

  // Compare: every cycle out of reset, rsp_valid must match the expected-response schedule.
  always @(negedge clk) begin
    if (!rst) begin
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        vectors++;
        cmp_e = exp_q.pop_front();
        void'(due_q.pop_front());
        if (!rsp_valid || rsp_rdata !== cmp_e[DW+1:2] || rsp_serr !== cmp_e[1] || rsp_derr !== cmp_e[0]) begin
          fails++;
          $display("FAIL rsp @%0d: got valid=%0b data=%h serr=%0b derr=%0b, want valid=1 data=%h serr=%0b derr=%0b",
                   cyc, rsp_valid, rsp_rdata, rsp_serr, rsp_derr, cmp_e[DW+1:2], cmp_e[1], cmp_e[0]);
        end
      end else if (rsp_valid) begin
        vectors++;
        fails++;
        $display("FAIL rsp_unexpected @%0d: got valid=1 data=%h, want valid=0", cyc, rsp_rdata);
      end
      if (rsp_valid) begin
        got_data = rsp_rdata; got_serr = rsp_serr; got_derr = rsp_derr;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // Driver tasks start and end just after a rising edge.
  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [CW-1:0] m);
    int n;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; inj_mask = m;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("req_accept_timeout", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; inj_mask = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    send(1'b0, a, '0, '0);
    idle(4);
  endtask

  task automatic check_csr(input string tag);
    @(negedge clk);
    chk({tag, "_serr_cnt"}, 64'(serr_cnt), 64'(m_serr));
    chk({tag, "_derr_cnt"}, 64'(derr_cnt), 64'(m_derr));
    chk({tag, "_last_err_addr"}, 64'(last_err_addr), 64'(m_last));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int stalls;
    logic [DW-1:0] d;
    chk("model_enc_0", 64'(m_encode(32'h0)), 64'h0);
    chk("model_enc_1", 64'(m_encode(32'h1)), 64'h0F);
    chk("model_enc_2", 64'(m_encode(32'h2)), 64'h33);

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 0);
    chk("rst_rsp_valid", 64'(rsp_valid), 0);
    chk("rst_serr_cnt", 64'(serr_cnt), 0);
    chk("rst_derr_cnt", 64'(derr_cnt), 0);
    chk("rst_last_err", 64'(last_err_addr), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 64'(req_ready), 1);
    @(posedge clk); #1;

    // Clean round trip
    send(1'b1, 6'd5, 32'hDEADBEEF, '0);
    rd(6'd5);
    chk("t1_rdata", 64'(got_data), 64'hDEADBEEF);
    chk("t1_serr", 64'(got_serr), 0);
    chk("t1_derr", 64'(got_derr), 0);
    check_csr("t1");

    // Single error corrected and written back
    send(1'b1, 6'd3, 32'h12345678, 39'h1 << 7);
    rd(6'd3);
    chk("t2_rdata", 64'(got_data), 64'h12345678);
    chk("t2_serr", 64'(got_serr), 1);
    chk("t2_serr_cnt", 64'(serr_cnt), 1);
    chk("t2_last_err", 64'(last_err_addr), 3);
    rd(6'd3);
    chk("t2_reread_serr", 64'(got_serr), 0);

    // Double error, no write-back
    send(1'b1, 6'd9, 32'hA5A55A5A, (39'h1 << 7) | (39'h1 << 12));
    rd(6'd9);
    chk("t3_derr", 64'(got_derr), 1);
    chk("t3_serr", 64'(got_serr), 0);
    chk("t3_derr_cnt", 64'(derr_cnt), 1);
    chk("t3_last_err", 64'(last_err_addr), 9);
    rd(6'd9);
    chk("t3_reread_derr", 64'(got_derr), 1);

    // Overall-parity bit only, then parity plus one more bit
    send(1'b1, 6'd10, 32'h0F0FA5A5, 39'h1);
    rd(6'd10);
    chk("t4_rdata", 64'(got_data), 64'h0F0FA5A5);
    chk("t4_serr", 64'(got_serr), 1);
    send(1'b1, 6'd11, 32'h00C0FFEE, 39'h21);
    rd(6'd11);
    chk("t4_derr", 64'(got_derr), 1);
    // Odd flips whose syndrome points past the codeword
    send(1'b1, 6'd12, 32'h13572468, (39'h1 << 32) | (39'h1 << 4) | (39'h1 << 3));
    rd(6'd12);
    chk("t4_syn_oor_derr", 64'(got_derr), 1);
    chk("t4_syn_oor_serr", 64'(got_serr), 0);
    // Injecting encode(1) over data 1 leaves an all-zero codeword
    send(1'b1, 6'd13, 32'h1, 39'h0F);
    rd(6'd13);
    chk("layout_rdata", 64'(got_data), 0);
    chk("layout_clean", 64'({got_serr, got_derr}), 0);
    check_csr("dir");

    // Counter saturation
    do_reset();
    for (int a = 40; a < 44; a++) begin
      send(1'b1, AW'(a), $urandom, 39'h1 << $urandom_range(0, CW - 1));
      rd(AW'(a));
    end
    chk("sat_serr_cnt", 64'(serr_cnt), 3);
    chk("sat_last_err", 64'(last_err_addr), 43);

    // Reset during write-back drops the correction
    send(1'b1, 6'd44, 32'h600DF00D, 39'h1 << 20);
    send(1'b0, 6'd44, '0, '0);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("wbrst_req_ready", 64'(req_ready), 0);
    chk("wbrst_rsp_valid", 64'(rsp_valid), 0);
    chk("wbrst_serr_cnt", 64'(serr_cnt), 0);
    chk("wbrst_last_err", 64'(last_err_addr), 0);
    @(posedge clk); #1 rst = 1'b0;
    rd(6'd44);
    chk("wbrst_reread_serr", 64'(got_serr), 1);
    chk("wbrst_reread_data", 64'(got_data), 64'h600DF00D);
    check_csr("wbrst");

    // Background scrub of address 0 while the host waits
    do_reset();
    send(1'b1, 6'd0, 32'hCAFEF00D, 39'h1 << 17);
    idle(2);
    scrub_en = 1'b1;
    idle(SI);
    req_valid = 1'b1; req_we = 1'b0; req_addr = '0;
    @(negedge clk);
    chk("scrub_pending_ready", 64'(req_ready), 0);
    mdl_mem[0] = m_encode(32'hCAFEF00D);
    m_serr = 1; m_last = '0;
    stalls = 0;
    while (!req_ready && stalls < 20) begin
      stalls++;
      @(negedge clk);
    end
    chk("scrub_stall_cycles", 64'(stalls), 4);
    chk("scrub_serr_cnt", 64'(serr_cnt), 1);
    chk("scrub_last_err", 64'(last_err_addr), 0);
    @(posedge clk); #1;
    req_valid = 1'b0; scrub_en = 1'b0;
    idle(4);
    chk("scrub_host_serr", 64'(got_serr), 0);
    chk("scrub_host_data", 64'(got_data), 64'hCAFEF00D);

    // Random traffic
    for (int a = 0; a < 16; a++) send(1'b1, AW'(a), $urandom, '0);
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        send(1'b1, AW'($urandom_range(0, 15)), d, rand_mask($urandom_range(0, 3)));
      end else begin
        rd(AW'($urandom_range(0, 15)));
        if (i % 4 == 0) check_csr("rnd");
      end
    end
    idle(4);
    check_csr("final");
    chk("final_queue_empty", 64'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/secded_mem_ctrl.md
Name: secded_mem_ctrl

Overview:
- Parametrised SECDED-protected word memory sitting between the core's load/store port and a register-array data store.
- Encodes on write and decodes/corrects on read for any DATA_W. Corrected words are written back on single-bit errors.
- A background scrubber walks the array periodically. Saturating error counters and a last-error-address log are exposed to the CSR block.

Parameters:
- DATA_W, 32, data word width (≥ 4)
- DEPTH, 64, number of words (power of two, ≥ 2)
- P_W, derived, smallest P with 2^P ≥ DATA_W+P+1 (6 for 32 bits); not overridable
- CODE_W, derived, DATA_W+P_W+1 (39 for 32 bits)
- SCRUB_INTERVAL, 1024, idle-timer cycles between scrub reads (≥ 4)
- CNT_W, 16, error counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  host request valid
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  clog2(DEPTH)  word address
- req_wdata  in  DATA_W  write data
- inj_mask  in  CODE_W  XORed into the codeword on host writes (fault injection; tie 0 in use)
- rsp_valid  out  1  read response valid, single-cycle pulse
- rsp_rdata  out  DATA_W  corrected read data
- rsp_serr  out  1  response had a corrected single error
- rsp_derr  out  1  response had an uncorrectable error
- scrub_en  in  1  enables the background scrubber
- serr_cnt  out  CNT_W  saturating single-error count
- derr_cnt  out  CNT_W  saturating double-error count
- last_err_addr  out  clog2(DEPTH)  address of the most recent error (host or scrub)

Behaviour:
- Reset values:
  - req_ready=0 during reset, 1 in the first cycle after release.
  - rsp_* = 0, counters = 0, last_err_addr = 0, scrub pointer = 0, scrub timer = 0, FSM = IDLE.
  - Array contents are not reset.
- Code layout:
  - Hamming positions 1..DATA_W+P_W map to codeword bits 1..DATA_W+P_W.
  - Check bit i sits at position 2^i. Data bits fill the non-power-of-two positions in ascending order, LSB first.
  - Bit 0 is overall parity, making the XOR of all CODE_W bits equal 0.
- Decode:
  - syn = XOR of the positions of all set bits (1..CODE_W-1); ov = XOR of all bits.
  - syn=0, ov=0: clean.
  - ov=1, syn=0: single error in bit 0. Counts as serr; data is already correct.
  - ov=1, 1 ≤ syn ≤ CODE_W-1: single error; flip bit syn.
  - ov=1, syn > CODE_W-1: uncorrectable, counts as derr.
  - ov=0, syn≠0: derr.
  - On derr, raw data bits are returned.
- FSM states: IDLE, RD, CHK, WB.
  - IDLE:
    - req_ready = !scrub_pending.
    - A write is accepted by req_valid&&req_ready&&req_we. It stores encode(req_wdata)^inj_mask at that clock edge and stays in IDLE, so back-to-back writes run at 1/cycle.
    - An accepted read goes to RD.
    - If scrub_pending is set, launch a scrub read of the scrub pointer, clear pending, and go to RD.
  - RD: registered array read; go to CHK.
  - CHK:
    - Decode the codeword.
    - For a host read, pulse rsp_valid with rsp_rdata/serr/derr in this cycle. Read latency is 2 cycles after acceptance.
    - Scrub reads produce no rsp_valid.
    - Any error increments the matching counter (saturating at all-ones) and loads last_err_addr.
    - serr goes to WB; otherwise go to IDLE.
    - A scrub read advances the pointer, wrapping DEPTH-1→0.
  - WB: write the re-encoded corrected word (inj_mask not applied) to the same address; go to IDLE.
- req_ready = 0 in RD, CHK, WB.
- Scrub timer:
  - Increments each cycle while scrub_en=1 and scrub_pending=0.
  - At SCRUB_INTERVAL-1 it sets scrub_pending and clears itself.
  - scrub_en=0 clears the timer and any pending scrub. A scrub already in flight completes.
- Scrub has priority over a simultaneous host request in IDLE.
- If an error and counter saturation occur in the same cycle, the counter holds at max while last_err_addr still updates.
- Reset mid-operation (any state) aborts to IDLE. An in-flight WB is dropped, so the array keeps the erroneous word.

Test Plan:
- Write 0xDEADBEEF to addr 5 with inj_mask=0, then read addr 5 → rsp_valid exactly 2 cycles after acceptance, rdata 0xDEADBEEF, serr=derr=0, counters unchanged.
- Write 0x12345678 to addr 3 with inj_mask bit 7 set, then read → rdata 0x12345678, serr=1, serr_cnt=1, last_err_addr=3. Read again → serr=0, proving WB.
- Write to addr 9 with inj_mask bits 7 and 12 set, then read → derr=1, serr=0, derr_cnt=1, last_err_addr=9. Read again → derr=1, proving no WB.
- Inject inj_mask=bit 0 only and read → data correct, serr=1. With inj_mask bits 0 and 5 → derr=1.
- SCRUB_INTERVAL=8, scrub_en=1, single error injected at addr 0, host idle → within 8+3 cycles serr_cnt=1 with no rsp_valid. A later host read of addr 0 is clean. req_valid asserted on the pending cycle is stalled (req_ready=0) until the scrub finishes.
- CNT_W=2: four single-error reads → serr_cnt stays at 3 while last_err_addr tracks the 4th address. Assert rst during WB → outputs reset, and a re-read still reports serr.
